sd_cmd_arbiter: RTL and testbench
=================================

# sd_cmd_arbiter

Shares the single SD command-master settings port between the SD data master (CMD17/18/24/25/12 issued during block transfers) and host-register command writes. It captures one requester's argument and setting words and drives the command-master write handshake. It then tracks command-master busy to completion and returns a done/error pulse to the owner. It sits between the data master, the host register file and the command master in the SD controller core.

## Interface
- ARG_W, 32, command argument width
- SET_W, 16, command setting word width (index, response type, CRC/index check enables)
- TMO_W, 8, timeout counter width
- TMO_MAX, 255, timeout threshold in clk cycles (must fit TMO_W)

- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- dm_req  in  1  data master command request; level, held until dm_gnt
- dm_arg  in  ARG_W  data master argument
- dm_set  in  SET_W  data master setting word
- dm_gnt  out  1  one-cycle pulse: command-master accepted dm command
- dm_done  out  1  one-cycle pulse: dm command finished
- host_req / host_arg / host_set / host_gnt / host_done  same as dm_*, host side
- done_err  out  1  qualifies *_done: 1 = transfer error or timeout
- tmo  out  1  one-cycle pulse with *_done when timeout aborted the command
- owner  out  1  0 = data master, 1 = host; valid while arb_busy
- arb_busy  out  1  high in every state except IDLE
- cm_we  out  1  write strobe to command master, held until cm_we_ack
- cm_arg  out  ARG_W  registered argument to command master
- cm_set  out  SET_W  registered setting to command master
- cm_we_ack  in  1  command master accepted write
- cm_busy  in  1  command master executing
- cm_tsf_err  in  1  command master transfer error

## Operation
- States: IDLE, WRITE, WAIT_BUSY, WAIT_IDLE.
- IDLE: if any req, select owner.
  - Tie rule: grant the requester that is not last_owner; last_owner resets to host, so dm wins the first tie.
  - Capture arg/set into cm_arg/cm_set, clear error flag and timeout counter, go WRITE.
- WRITE: cm_we=1. On cm_we_ack: drop cm_we, pulse owner's gnt next cycle, update last_owner, go WAIT_BUSY.
- WAIT_BUSY: on cm_busy=1 go WAIT_IDLE. If cm_busy is already high on entry, advance on the next cycle.
- WAIT_IDLE: on cm_busy=0 pulse owner's done with done_err, go IDLE.
- Error flag: set by cm_tsf_err in WAIT_BUSY or WAIT_IDLE; sticky until next selection.
- Requests are sampled only in IDLE. Dropping req after capture does not cancel the command.
- Req still high in IDLE after done is treated as a new request.
- Non-owner req is ignored while arb_busy.
- Reset at any time: immediate return to IDLE, all outputs 0, no done pulse.
- Reset values: every output 0, cm_arg/cm_set 0, last_owner=host.

## Timing
- All outputs registered.
- req high in IDLE at edge N -> cm_we=1, cm_arg/cm_set valid, arb_busy=1, owner valid from N+1.
- cm_we_ack high at edge M -> cm_we=0 and gnt=1 at M+1; gnt low at M+2.
- cm_busy falls at edge K in WAIT_IDLE -> done=1 (with done_err) at K+1, arb_busy=0 at K+1. New selection is possible at K+1, so the next cm_we appears at K+2.
- Minimum transaction: 4 cycles from selection to IDLE.
- cm_tsf_err in the same cycle as the cm_busy fall is captured and reported.

## Configuration
- SD_CMD_ARB_TIMEOUT_EN defined:
  - Counter increments each cycle in WRITE and WAIT_BUSY.
  - Reaching TMO_MAX aborts: cm_we=0, owner's done=1, done_err=1, tmo=1 for one cycle, back to IDLE.
  - No gnt is issued if the abort happens in WRITE.
- Undefined: no counter, states wait indefinitely, tmo tied 0.

## Test plan
- dm_req=1, arg=0x00000200, set=0x1139; cm_we_ack 3 cycles later; cm_busy high 5 cycles then low -> cm_arg=0x200, single dm_gnt, single dm_done, done_err=0, owner=0.
- dm_req and host_req rise on the same cycle after reset -> dm served first. Host is served immediately after dm_done with no idle gap beyond one cycle. In the next tie, dm waits.
- cm_tsf_err pulsed 1 cycle during WAIT_IDLE -> host_done with done_err=1, tmo=0.
- rst asserted mid-WAIT_IDLE -> outputs 0 asynchronously, no done; after release, pending req is re-granted.
- cm_we_ack never asserted, SD_CMD_ARB_TIMEOUT_EN defined -> done, done_err and tmo pulse 255 cycles after WRITE entry, no gnt. With the macro undefined -> cm_we stays high indefinitely.
- cm_busy already high when cm_we_ack arrives -> WAIT_BUSY exits next cycle, done follows the cm_busy fall by one cycle.

Source files
------------

// File: rtl/sd_cmd_arbiter.sv
// Arbitrates the single SD command-master settings port between the data master and host registers.
// Optional abort-on-timeout is compiled in with `define SD_CMD_ARB_TIMEOUT_EN.
module sd_cmd_arbiter #(
  parameter int ARG_W   = 32,
  parameter int SET_W   = 16,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dm_req,
  input  logic [ARG_W-1:0] dm_arg,
  input  logic [SET_W-1:0] dm_set,
  output logic             dm_gnt,
  output logic             dm_done,
  input  logic             host_req,
  input  logic [ARG_W-1:0] host_arg,
  input  logic [SET_W-1:0] host_set,
  output logic             host_gnt,
  output logic             host_done,
  output logic             done_err,
  output logic             tmo,
  output logic             owner,
  output logic             arb_busy,
  output logic             cm_we,
  output logic [ARG_W-1:0] cm_arg,
  output logic [SET_W-1:0] cm_set,
  input  logic             cm_we_ack,
  input  logic             cm_busy,
  input  logic             cm_tsf_err
);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_BUSY, WAIT_IDLE} state_t;

  state_t state;
  logic   last_owner;
  logic   err;
  logic   sel_host;

  // On a tie the side that did not own the previous command wins.
  assign sel_host = host_req & (~dm_req | ~last_owner);

`ifdef SD_CMD_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Compare against TMO_MAX-1 so the abort pulse lands TMO_MAX cycles after WRITE entry.
  assign tmo_hit = (tmo_cnt >= TMO_W'(TMO_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (state == WRITE || state == WAIT_BUSY) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TMO_W'(TMO_MAX);
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      err        <= 1'b0;
      owner      <= 1'b0;
      arb_busy   <= 1'b0;
      cm_we      <= 1'b0;
      cm_arg     <= '0;
      cm_set     <= '0;
      dm_gnt     <= 1'b0;
      host_gnt   <= 1'b0;
      dm_done    <= 1'b0;
      host_done  <= 1'b0;
      done_err   <= 1'b0;
`ifdef SD_CMD_ARB_TIMEOUT_EN
      tmo        <= 1'b0;
`endif
    end else begin
      dm_gnt    <= 1'b0;
      host_gnt  <= 1'b0;
      dm_done   <= 1'b0;
      host_done <= 1'b0;
      done_err  <= 1'b0;
`ifdef SD_CMD_ARB_TIMEOUT_EN
      tmo       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (dm_req || host_req) begin
            owner    <= sel_host;
            cm_arg   <= sel_host ? host_arg : dm_arg;
            cm_set   <= sel_host ? host_set : dm_set;
            err      <= 1'b0;
            cm_we    <= 1'b1;
            arb_busy <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (cm_we_ack) begin
            cm_we      <= 1'b0;
            dm_gnt     <= ~owner;
            host_gnt   <= owner;
            last_owner <= owner;
            state      <= WAIT_BUSY;
          end
`ifdef SD_CMD_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            cm_we     <= 1'b0;
            dm_done   <= ~owner;
            host_done <= owner;
            done_err  <= 1'b1;
            tmo       <= 1'b1;
            arb_busy  <= 1'b0;
            state     <= IDLE;
          end
`endif
        end
        WAIT_BUSY: begin
          err <= err | cm_tsf_err;
          if (cm_busy) begin
            state <= WAIT_IDLE;
          end
`ifdef SD_CMD_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            dm_done   <= ~owner;
            host_done <= owner;
            done_err  <= 1'b1;
            tmo       <= 1'b1;
            arb_busy  <= 1'b0;
            state     <= IDLE;
          end
`endif
        end
        WAIT_IDLE: begin
          err <= err | cm_tsf_err;
          // An error flagged on the same edge as the busy fall still counts.
          if (!cm_busy) begin
            dm_done   <= ~owner;
            host_done <= owner;
            done_err  <= err | cm_tsf_err;
            arb_busy  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Directed bench for sd_cmd_arbiter; inputs change and outputs are sampled 1ns after each rising edge.
module tb_sd_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        dm_req, host_req;
  logic [31:0] dm_arg, host_arg;
  logic [15:0] dm_set, host_set;
  logic        dm_gnt, dm_done, host_gnt, host_done;
  logic        done_err, tmo, owner, arb_busy, cm_we;
  logic [31:0] cm_arg;
  logic [15:0] cm_set;
  logic        cm_we_ack, cm_busy, cm_tsf_err;

  int checks   = 0;
  int failures = 0;

  sd_cmd_arbiter #(.ARG_W(32), .SET_W(16), .TMO_W(8), .TMO_MAX(255)) dut (
    .clk(clk), .rst(rst),
    .dm_req(dm_req), .dm_arg(dm_arg), .dm_set(dm_set), .dm_gnt(dm_gnt), .dm_done(dm_done),
    .host_req(host_req), .host_arg(host_arg), .host_set(host_set), .host_gnt(host_gnt),
    .host_done(host_done), .done_err(done_err), .tmo(tmo), .owner(owner), .arb_busy(arb_busy),
    .cm_we(cm_we), .cm_arg(cm_arg), .cm_set(cm_set), .cm_we_ack(cm_we_ack),
    .cm_busy(cm_busy), .cm_tsf_err(cm_tsf_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    dm_req = 1'b0; host_req = 1'b0;
    dm_arg = '0; dm_set = '0; host_arg = '0; host_set = '0;
    cm_we_ack = 1'b0; cm_busy = 1'b0; cm_tsf_err = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_outs", 64'({cm_we, arb_busy, owner, dm_gnt, host_gnt, dm_done, host_done, done_err, tmo}), 64'h0);
    chk("reset_cm_arg", 64'(cm_arg), 64'h0);
    chk("reset_cm_set", 64'(cm_set), 64'h0);

    // Basic dm command: ack 3 cycles into WRITE, busy high 5 cycles
    dm_req = 1'b1; dm_arg = 32'h0000_0200; dm_set = 16'h1139;
    step();
    chk("t1_sel", 64'({cm_we, arb_busy, owner}), 64'b110);
    chk("t1_arg", 64'(cm_arg), 64'h200);
    chk("t1_set", 64'(cm_set), 64'h1139);
    step(); step();
    chk("t1_we_held", 64'({cm_we, dm_gnt}), 64'b10);
    cm_we_ack = 1'b1;
    step();
    chk("t1_gnt", 64'({cm_we, dm_gnt, host_gnt}), 64'b010);
    cm_we_ack = 1'b0; dm_req = 1'b0;
    step();
    chk("t1_gnt_pulse", 64'({dm_gnt, arb_busy}), 64'b01);
    cm_busy = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t1_no_early_done", 64'({dm_done, arb_busy}), 64'b01);
    cm_busy = 1'b0;
    step();
    chk("t1_done", 64'({dm_done, host_done, done_err, tmo, arb_busy}), 64'b10000);
    step();
    chk("t1_done_pulse", 64'({dm_done, arb_busy, cm_we}), 64'b000);

    // Fresh reset so last_owner is host: first tie goes to dm
    rst = 1'b1; step(); rst = 1'b0;
    dm_req = 1'b1; dm_arg = 32'hA; host_req = 1'b1; host_arg = 32'hB; host_set = 16'h0B0B;
    step();
    chk("t2_tie_dm", 64'({owner, cm_we}), 64'b01);
    chk("t2_tie_arg", 64'(cm_arg), 64'hA);
    cm_we_ack = 1'b1;
    step();
    chk("t2_dm_gnt", 64'({dm_gnt, host_gnt}), 64'b10);
    cm_we_ack = 1'b0; dm_req = 1'b0; cm_busy = 1'b1;
    step();
    cm_busy = 1'b0;
    step();
    chk("t2_dm_done", 64'({dm_done, host_done, done_err, arb_busy}), 64'b1000);
    // dm re-requests: now a tie again, and dm must wait
    dm_req = 1'b1; dm_arg = 32'hC;
    step();
    chk("t2_host_next", 64'({owner, cm_we, arb_busy}), 64'b111);
    chk("t2_host_arg", 64'(cm_arg), 64'hB);
    chk("t2_host_set", 64'(cm_set), 64'h0B0B);
    cm_we_ack = 1'b1;
    step();
    chk("t2_host_gnt", 64'({dm_gnt, host_gnt}), 64'b01);
    cm_we_ack = 1'b0; host_req = 1'b0; cm_busy = 1'b1;
    step();
    // Transfer error pulse during WAIT_IDLE
    cm_tsf_err = 1'b1;
    step();
    cm_tsf_err = 1'b0;
    step();
    chk("t3_nonowner_ignored", 64'({owner, cm_arg}), {31'h0, 1'b1, 32'hB});
    cm_busy = 1'b0;
    step();
    chk("t3_host_err_done", 64'({host_done, dm_done, done_err, tmo}), 64'b1010);
    step();
    chk("t3_dm_after", 64'({owner, cm_we}), 64'b01);
    chk("t3_dm_arg", 64'(cm_arg), 64'hC);
    cm_we_ack = 1'b1;
    step();
    cm_we_ack = 1'b0; dm_req = 1'b0; cm_busy = 1'b1;
    step(); step();
    cm_busy = 1'b0;
    step();
    chk("t3_err_cleared", 64'({dm_done, done_err}), 64'b10);

    // Error on the same edge as the busy fall
    dm_req = 1'b1; dm_arg = 32'h12;
    step();
    cm_we_ack = 1'b1;
    step();
    cm_we_ack = 1'b0; dm_req = 1'b0; cm_busy = 1'b1;
    step(); step();
    cm_busy = 1'b0; cm_tsf_err = 1'b1;
    step();
    cm_tsf_err = 1'b0;
    chk("t3b_err_at_fall", 64'({dm_done, done_err, tmo}), 64'b110);

    // Reset in the middle of WAIT_IDLE, host request held
    host_req = 1'b1; host_arg = 32'h77;
    step();
    cm_we_ack = 1'b1;
    step();
    cm_we_ack = 1'b0; cm_busy = 1'b1;
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("t4_async_rst", 64'({cm_we, arb_busy, owner, host_done, host_gnt, done_err}), 64'h0);
    chk("t4_rst_arg", 64'(cm_arg), 64'h0);
    cm_busy = 1'b0;
    step();
    chk("t4_no_done", 64'({host_done, dm_done, arb_busy}), 64'b000);
    rst = 1'b0;
    step();
    chk("t4_regrant", 64'({owner, cm_we, arb_busy}), 64'b111);
    chk("t4_regrant_arg", 64'(cm_arg), 64'h77);
    cm_we_ack = 1'b1;
    step();
    chk("t4_host_gnt", 64'({host_gnt, dm_gnt}), 64'b10);
    cm_we_ack = 1'b0; host_req = 1'b0; cm_busy = 1'b1;
    step();
    cm_busy = 1'b0;
    step();
    chk("t4_done", 64'({host_done, done_err}), 64'b10);

    // cm_busy already high when ack arrives
    dm_req = 1'b1; dm_arg = 32'h55; cm_busy = 1'b1;
    step();
    cm_we_ack = 1'b1;
    step();
    chk("t6_gnt", 64'(dm_gnt), 64'b1);
    cm_we_ack = 1'b0; dm_req = 1'b0;
    step();
    chk("t6_waiting", 64'({dm_done, arb_busy}), 64'b01);
    cm_busy = 1'b0;
    step();
    chk("t6_done", 64'({dm_done, arb_busy}), 64'b10);

    // Ack never arrives
    dm_req = 1'b1; dm_arg = 32'h99;
    step();
    pulses = 0;
`ifdef SD_CMD_ARB_TIMEOUT_EN
    for (int i = 1; i < 255; i++) begin
      step();
      pulses += int'(dm_done) + int'(tmo) + int'(dm_gnt);
    end
    chk("t5_no_early_tmo", 64'(pulses), 64'h0);
    chk("t5_we_held", 64'(cm_we), 64'b1);
    step();
    dm_req = 1'b0;
    chk("t5_tmo_abort", 64'({dm_done, host_done, done_err, tmo, dm_gnt, cm_we, arb_busy}), 64'b1011000);
    step();
    chk("t5_tmo_pulse", 64'({tmo, dm_done}), 64'b00);
`else
    for (int i = 0; i < 300; i++) begin
      step();
      pulses += int'(dm_done) + int'(tmo) + int'(dm_gnt) + int'(!cm_we);
    end
    chk("t5_we_indefinite", 64'(pulses), 64'h0);
    dm_req = 1'b0; cm_we_ack = 1'b1;
    step();
    cm_we_ack = 1'b0; cm_busy = 1'b1;
    step();
    cm_busy = 1'b0;
    step();
    chk("t5_late_done", 64'({dm_done, done_err, tmo}), 64'b100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
